// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among NREQ requesters.
// Optional signed-overflow output enabled by defining ADDER_ARB_OVF_EN.
module adder_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_s,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
`ifdef ADDER_ARB_OVF_EN
  output logic                  rsp_ovf,
`endif
  output logic                  rsp_cout
);

  localparam logic [0:0]     STATE_EMPTY = 1'b0;
  localparam logic [0:0]     STATE_FULL  = 1'b1;
  localparam logic [IDW-1:0] LAST_IDX    = IDW'(NREQ - 1);

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_ptr_next;
  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic             can_issue;
  logic             grant;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_sub;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : scan
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  // Reset suppresses grants so no transfer is signalled while the response stage is cleared.
  assign can_issue = rst_n & ((state_q == STATE_EMPTY) | rsp_ready);
  assign grant     = win_found & can_issue;

  always_comb begin : ready_gen
    req_ready = '0;
    if (grant) req_ready[win_idx] = 1'b1;
  end

  assign sel_a   = req_a[int'(win_idx)*WIDTH +: WIDTH];
  assign sel_b   = req_b[int'(win_idx)*WIDTH +: WIDTH];
  assign sel_sub = req_sub[win_idx];

  // Subtraction is A + ~B + 1, so the adder sees the inverted operand and carry-in.
  assign add_a   = win_found ? sel_a : '0;
  assign add_b   = win_found ? (sel_sub ? ~sel_b : sel_b) : '0;
  assign add_cin = win_found & sel_sub;

  assign rr_ptr_next = (win_idx == LAST_IDX) ? '0 : win_idx + IDW'(1);

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      STATE_EMPTY: if (grant) state_d = STATE_FULL;
      STATE_FULL:  if (!grant && rsp_ready) state_d = STATE_EMPTY;
      default:     state_d = STATE_EMPTY;
    endcase
  end

  assign rsp_valid = (state_q == STATE_FULL);

  // NOTE: synchronous reset lives inside the clocked block; all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= STATE_EMPTY;
      rr_ptr   <= '0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        rr_ptr   <= rr_ptr_next;
        rsp_id   <= win_idx;
        rsp_sum  <= add_s;
        rsp_cout <= add_cout;
      end
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic ovf_d;

  assign ovf_d = (add_a[WIDTH-1] == add_b[WIDTH-1]) & (add_s[WIDTH-1] != add_a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_ovf <= 1'b0;
    end else if (grant) begin
      rsp_ovf <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter; models the external adder behaviourally.
module tb_adder_rr_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_sub;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic                  add_cin;
  logic [WIDTH-1:0]      add_s;
  logic                  add_cout;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
`ifdef ADDER_ARB_OVF_EN
  logic                  rsp_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic [WIDTH:0] full_sum;
  assign full_sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  assign add_s    = full_sum[WIDTH-1:0];
  assign add_cout = full_sum[WIDTH];

  adder_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
`ifdef ADDER_ARB_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .rsp_cout(rsp_cout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b1;
    step(); step();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_sum !== 32'h0) begin failures++; $display("FAIL reset_sum got=%h exp=0", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", rsp_cout); end
`ifdef ADDER_ARB_OVF_EN
    checks++; if (rsp_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", rsp_ovf); end
`endif
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL first_grant got=%b exp=0001", req_ready); end
  endtask

  task automatic test_add();
    req_valid = 4'b0001; req_sub = '0;
    req_a[0 +: WIDTH] = 32'hBABEFACE; req_b[0 +: WIDTH] = 32'hDEADBEEF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL add_ready got=%b exp=0001", req_ready); end
    checks++; if (add_a !== 32'hBABEFACE || add_b !== 32'hDEADBEEF || add_cin !== 1'b0) begin
      failures++; $display("FAIL add_operands got=%h/%h/%b exp=babeface/deadbeef/0", add_a, add_b, add_cin);
    end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin failures++; $display("FAIL add_rsp got=v%b id%0d exp=v1 id0", rsp_valid, rsp_id); end
    checks++; if (rsp_sum !== 32'h996CB9BD || rsp_cout !== 1'b1) begin
      failures++; $display("FAIL add_sum got=%h c%b exp=996cb9bd c1", rsp_sum, rsp_cout);
    end
    req_valid = '0;
    step();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_sub();
    logic [31:0] va [2] = '{32'h10, 32'h1};
    logic [31:0] vb [2] = '{32'h1, 32'h2};
    logic [31:0] vs [2] = '{32'h0000000F, 32'hFFFFFFFF};
    logic        vc [2] = '{1'b1, 1'b0};
    req_valid = 4'b0100; req_sub = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      req_a[2*WIDTH +: WIDTH] = va[i]; req_b[2*WIDTH +: WIDTH] = vb[i];
      #1;
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL sub_ready[%0d] got=%b exp=0100", i, req_ready); end
      checks++; if (add_b !== ~vb[i] || add_cin !== 1'b1) begin
        failures++; $display("FAIL sub_operand[%0d] got=%h c%b exp=%h c1", i, add_b, add_cin, ~vb[i]);
      end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== vs[i] || rsp_cout !== vc[i]) begin
        failures++; $display("FAIL sub_rsp[%0d] got=v%b id%0d %h c%b exp=v1 id2 %h c%b",
                             i, rsp_valid, rsp_id, rsp_sum, rsp_cout, vs[i], vc[i]);
      end
    end
    req_valid = '0; req_sub = '0;
    step();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = i * 32'h100 + 32'h1;
      req_b[i*WIDTH +: WIDTH] = i;
    end
    req_valid = 4'b1111; req_sub = '0;
    for (int k = 0; k < 6; k++) begin
      int w;
      w = k % NREQ;
      #1;
      checks++; if (req_ready !== (4'b0001 << w)) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, 4'b0001 << w); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== w[1:0] || rsp_sum !== (w * 32'h101 + 32'h1)) begin
        failures++; $display("FAIL rr_rsp[%0d] got=v%b id%0d %h exp=v1 id%0d %h", k, rsp_valid, rsp_id, rsp_sum, w, w * 32'h101 + 32'h1);
      end
    end
    req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL solo_ready[%0d] got=%b exp=1000", k, req_ready); end
      step();
      checks++; if (rsp_id !== 2'd3 || rsp_sum !== 32'h304) begin failures++; $display("FAIL solo_rsp[%0d] got=id%0d %h exp=id3 304", k, rsp_id, rsp_sum); end
    end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_first got=%b exp=0001", req_ready); end
    step();
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, req_ready); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'h1 || rsp_cout !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d] got=v%b id%0d %h c%b exp=v1 id0 00000001 c0", k, rsp_valid, rsp_id, rsp_sum, rsp_cout);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_resume got=%b exp=0010", req_ready); end
    step();
    checks++; if (rsp_id !== 2'd1 || rsp_sum !== 32'h102) begin failures++; $display("FAIL bp_next got=id%0d %h exp=id1 102", rsp_id, rsp_sum); end
    rsp_ready = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin failures++; $display("FAIL bp_stall2 got=v%b id%0d exp=v1 id1", rsp_valid, rsp_id); end
    rst_n = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 32'h0) begin
      failures++; $display("FAIL bp_reset got=v%b id%0d %h exp=v0 id0 0", rsp_valid, rsp_id, rsp_sum);
    end
    rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    step();
  endtask

  task automatic test_overflow();
    logic [31:0] va [3] = '{32'h7FFFFFFF, 32'h80000000, 32'h5};
    logic [31:0] vb [3] = '{32'h1, 32'h1, 32'h3};
    logic        vu [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] vs [3] = '{32'h80000000, 32'h7FFFFFFF, 32'h8};
    logic        vc [3] = '{1'b0, 1'b1, 1'b0};
    logic        vo [3] = '{1'b1, 1'b1, 1'b0};
    req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      req_a[WIDTH +: WIDTH] = va[i]; req_b[WIDTH +: WIDTH] = vb[i]; req_sub[1] = vu[i];
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== vs[i] || rsp_cout !== vc[i]) begin
        failures++; $display("FAIL ovf_sum[%0d] got=v%b id%0d %h c%b exp=v1 id1 %h c%b", i, rsp_valid, rsp_id, rsp_sum, rsp_cout, vs[i], vc[i]);
      end
`ifdef ADDER_ARB_OVF_EN
      checks++; if (rsp_ovf !== vo[i]) begin failures++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", i, rsp_ovf, vo[i]); end
`else
      if (vo[i] === 1'bx) $display("unexpected table entry %0d", i);
`endif
    end
    req_valid = '0; req_sub = '0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
